// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the LCD command sequencer.
//   - 4-bit opcode constants (WRITE .. MIRROR_Y); codes 12..15 are unassigned.
//   - Sequencer FSM state enum.
//   - Default FIFO depth and the WAIT_ACK timeout length.
//   - is_filtered(): true for the unassigned opcodes. Only used when
//     LCD_CMD_FILTER_EN is defined.
package lcd_pkg;

  localparam int DEF_DEPTH   = 8;
  // Number of busy==0 cycles tolerated in WAIT_ACK before the command is
  // treated as already completed.
  localparam int ACK_TIMEOUT = 4;

  localparam logic [3:0] OP_WRITE      = 4'd0;
  localparam logic [3:0] OP_READ       = 4'd1;
  localparam logic [3:0] OP_CLEAR      = 4'd2;
  localparam logic [3:0] OP_HOME       = 4'd3;
  localparam logic [3:0] OP_DISP_ON    = 4'd4;
  localparam logic [3:0] OP_DISP_OFF   = 4'd5;
  localparam logic [3:0] OP_CURSOR_ON  = 4'd6;
  localparam logic [3:0] OP_CURSOR_OFF = 4'd7;
  localparam logic [3:0] OP_SCROLL_L   = 4'd8;
  localparam logic [3:0] OP_SCROLL_R   = 4'd9;
  localparam logic [3:0] OP_MIRROR_X   = 4'd10;
  localparam logic [3:0] OP_MIRROR_Y   = 4'd11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_HALT
  } seq_state_e;

  function automatic logic is_filtered(input logic [3:0] op);
    return op > OP_MIRROR_Y;
  endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// lcd_cmd_fifo: synchronous DEPTH x 4 command FIFO.
//   clk, reset (async, active low)
//   push, wdata : write port (caller guarantees !full)
//   pop, rdata  : read port; rdata is the current head, valid when !empty
//   full, empty : registered-state flags
//   level       : occupancy 0..DEPTH
// Flags derive only from the registered count, so a push is not visible to
// the read side until the next cycle and a pop never frees a slot for a push
// in the same cycle.
module lcd_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int LW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [3:0]    wdata,
  input  logic          pop,
  output logic [3:0]    rdata,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [LW-1:0] count;

  assign full  = (count == LW'(DEPTH));
  assign empty = (count == '0);
  assign level = count;
  assign rdata = mem[rptr];

  // Storage has no reset; only pointers and count define contents.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lcd_cmd_seq.sv
// lcd_cmd_seq: queues host opcodes and issues them one at a time to an LCD
// controller, pacing on the controller's busy/done handshake.
//   clk, reset            : clock, async active-low reset
//   host_cmd/valid/ready  : host push port into the command FIFO
//   cmd, cmd_valid        : issued opcode and one-cycle issue strobe
//   busy, done            : controller status
//   level                 : FIFO occupancy
//   halted                : a Write completed; sequencer stopped until reset
// Build option: define LCD_CMD_FILTER_EN to drop opcodes 12..15 at the push
// port (handshake still completes, nothing is stored).
module lcd_cmd_seq
  import lcd_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int LW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    host_cmd,
  input  logic          host_valid,
  output logic          host_ready,
  output logic [3:0]    cmd,
  output logic          cmd_valid,
  input  logic          busy,
  input  logic          done,
  output logic [LW-1:0] level,
  output logic          halted
);

  localparam logic [1:0] ACK_LAST = 2'(ACK_TIMEOUT - 1);

  seq_state_e state;
  logic       is_write;
  logic [1:0] ack_cnt;
  logic       push, pop, full, empty;
  logic [3:0] fifo_rdata;

  assign host_ready = !full && !halted;

`ifdef LCD_CMD_FILTER_EN
  assign push = host_valid && host_ready && !is_filtered(host_cmd);
`else
  assign push = host_valid && host_ready;
`endif

  // Pop only when the controller is idle; busy gating here keeps cmd_valid
  // from ever being raised on a cycle following busy==1.
  assign pop = (state == S_IDLE) && !empty && !busy;

  lcd_cmd_fifo #(.DEPTH(DEPTH), .LW(LW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (host_cmd),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cmd       <= '0;
      cmd_valid <= 1'b0;
      halted    <= 1'b0;
      is_write  <= 1'b0;
      ack_cnt   <= '0;
    end else begin
      cmd_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (pop) begin
            cmd       <= fifo_rdata;
            is_write  <= (fifo_rdata == OP_WRITE);
            cmd_valid <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          ack_cnt <= '0;
          state   <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          // A controller that never raises busy is assumed to have finished.
          if (busy)                   state   <= S_WAIT_DONE;
          else if (ack_cnt == ACK_LAST) state <= S_IDLE;
          else                        ack_cnt <= ack_cnt + 1'b1;
        end
        S_WAIT_DONE: begin
          // A Write ends the sequence: wait for done, not for busy to drop.
          if (is_write) begin
            if (done) begin
              state  <= S_HALT;
              halted <= 1'b1;
            end
          end else if (!busy) begin
            state <= S_IDLE;
          end
        end
        S_HALT:  halted <= 1'b1;
        default: state  <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_cmd_seq.sv
module tb_lcd_cmd_seq;
  localparam int DEPTH = 8;
  localparam int LW    = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [3:0]    host_cmd = '0;
  logic          host_valid = 1'b0;
  logic          host_ready;
  logic [3:0]    cmd;
  logic          cmd_valid;
  logic          busy = 1'b0;
  logic          done = 1'b0;
  logic [LW-1:0] level;
  logic          halted;

  always #5 clk = ~clk;

  lcd_cmd_seq #(.DEPTH(DEPTH), .LW(LW)) dut (
    .clk(clk), .reset(reset), .host_cmd(host_cmd), .host_valid(host_valid),
    .host_ready(host_ready), .cmd(cmd), .cmd_valid(cmd_valid), .busy(busy),
    .done(done), .level(level), .halted(halted)
  );

  typedef struct { logic [3:0] op; logic bsy; int cyc; } strobe_t;
  strobe_t    obs_q[$];
  logic [3:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Controller model: busy rises ctl_lat cycles after a strobe and stays for
  // ctl_len cycles (0 = never rises); a Write gets a done pulse as busy falls.
  int   ctl_lat = 2;
  int   ctl_len = 6;
  logic force_busy = 1'b0;
  int   k = -1;
  logic [3:0] k_op = '0;
  logic busy_m = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (cmd_valid) obs_q.push_back('{cmd, busy, cyc});
    done = 1'b0;
    if (!reset) begin
      k = -1;
      busy_m = 1'b0;
    end else begin
      if (cmd_valid) begin
        k = 0;
        k_op = cmd;
      end else if (k >= 0) k++;
      busy_m = (k >= 0) && (ctl_len > 0) && (k >= ctl_lat) && (k < ctl_lat + ctl_len);
      if (k >= 0 && ctl_len > 0 && k == ctl_lat + ctl_len && k_op == 4'd0) done = 1'b1;
      if (k > ctl_lat + ctl_len) k = -1;
    end
    busy = force_busy | busy_m;
  end

  function automatic bit keep(input logic [3:0] op);
`ifdef LCD_CMD_FILTER_EN
    return op < 4'd12;
`else
    return 1'b1;
`endif
  endfunction

  task automatic push_op(input logic [3:0] op, output logic acc);
    @(negedge clk); #1;
    host_cmd = op;
    host_valid = 1'b1;
    acc = host_ready;
    if (acc && keep(op)) exp_q.push_back(op);
  endtask

  task automatic end_push();
    @(negedge clk); #1;
    host_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    reset = 1'b0;
    host_valid = 1'b0;
    force_busy = 1'b0;
    #1;
    obs_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic wait_strobes(input int n, input int budget, output bit ok);
    int c = 0;
    while (obs_q.size() < n && c < budget) begin
      @(negedge clk); #2;
      c++;
    end
    ok = (obs_q.size() >= n);
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (level !== '0 || cmd_valid !== 1'b0 || halted !== 1'b0 || cmd !== 4'd0) begin
      errors++;
      $display("FAIL reset_state: level=%0d cmd_valid=%b halted=%b cmd=%0d, need 0/0/0/0",
               level, cmd_valid, halted, cmd);
    end
    @(negedge clk); #1 reset = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (host_ready !== 1'b1 || cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: host_ready=%b cmd_valid=%b, need 1/0", host_ready, cmd_valid);
    end
  endtask

  task automatic test_in_order();
    logic acc;
    bit ok;
    do_reset();
    ctl_lat = 2; ctl_len = 6;
    push_op(4'd1, acc); push_op(4'd5, acc); push_op(4'd9, acc);
    end_push();
    wait_strobes(3, 200, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL in_order_timeout: got %0d strobes, need 3", obs_q.size());
    end
    repeat (20) @(negedge clk);
    #2;
    checks++;
    if (obs_q.size() != 3) begin
      errors++;
      $display("FAIL in_order_count: got %0d strobes, need 3", obs_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < 3; i++) begin
      checks++;
      if (obs_q[i].op !== exp_q[i] || obs_q[i].bsy !== 1'b0) begin
        errors++;
        $display("FAIL in_order_op%0d: op=%0d busy=%b, need op=%0d busy=0",
                 i, obs_q[i].op, obs_q[i].bsy, exp_q[i]);
      end
      if (i > 0) begin
        checks++;
        if (obs_q[i].cyc - obs_q[i-1].cyc < 3) begin
          errors++;
          $display("FAIL in_order_gap%0d: gap=%0d, need >=3", i, obs_q[i].cyc - obs_q[i-1].cyc);
        end
      end
    end
    checks++;
    if (cmd !== 4'd9) begin
      errors++;
      $display("FAIL cmd_hold: cmd=%0d, need 9", cmd);
    end
  endtask

  task automatic test_full();
    logic acc;
    bit ok;
    do_reset();
    force_busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      push_op(4'(i + 1), acc);
      checks++;
      if (acc !== 1'b1) begin
        errors++;
        $display("FAIL full_accept%0d: host_ready=%b, need 1", i, acc);
      end
    end
    push_op(4'd9, acc);
    checks++;
    if (acc !== 1'b0 || level !== LW'(DEPTH)) begin
      errors++;
      $display("FAIL full_ninth: host_ready=%b level=%0d, need 0/%0d", acc, level, DEPTH);
    end
    end_push();
    #1;
    checks++;
    if (level !== LW'(DEPTH)) begin
      errors++;
      $display("FAIL full_level: level=%0d, need %0d", level, DEPTH);
    end
    ctl_lat = 1; ctl_len = 2;
    force_busy = 1'b0;
    wait_strobes(DEPTH, 400, ok);
    repeat (20) @(negedge clk);
    #2;
    checks++;
    if (obs_q.size() != DEPTH || exp_q.size() != DEPTH) begin
      errors++;
      $display("FAIL full_drain_count: got %0d strobes, %0d expected entries, need %0d",
               obs_q.size(), exp_q.size(), DEPTH);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i].op !== exp_q[i]) begin
        errors++;
        $display("FAIL full_drain_op%0d: op=%0d, need %0d", i, obs_q[i].op, exp_q[i]);
      end
    end
  endtask

  task automatic test_timeout();
    logic acc;
    bit ok;
    do_reset();
    ctl_lat = 2; ctl_len = 0;
    push_op(4'd4, acc); push_op(4'd6, acc);
    end_push();
    wait_strobes(2, 100, ok);
    checks++;
    if (!ok || obs_q[0].op !== 4'd4 || obs_q[1].op !== 4'd6) begin
      errors++;
      $display("FAIL timeout_ops: strobes=%0d, need 2 with ops 4,6", obs_q.size());
    end else begin
      // ISSUE + 4 WAIT_ACK + IDLE between strobes
      checks++;
      if (obs_q[1].cyc - obs_q[0].cyc != 6) begin
        errors++;
        $display("FAIL timeout_gap: gap=%0d, need 6", obs_q[1].cyc - obs_q[0].cyc);
      end
    end
  endtask

  task automatic test_halt();
    logic acc;
    bit ok;
    do_reset();
    ctl_lat = 2; ctl_len = 6;
    push_op(4'd3, acc); push_op(4'd0, acc); push_op(4'd7, acc);
    end_push();
    wait_strobes(2, 200, ok);
    repeat (30) @(negedge clk);
    #2;
    checks++;
    if (obs_q.size() != 2 || obs_q[0].op !== 4'd3 || obs_q[1].op !== 4'd0) begin
      errors++;
      $display("FAIL halt_strobes: got %0d strobes, need exactly ops 3,0", obs_q.size());
    end
    checks++;
    if (halted !== 1'b1 || host_ready !== 1'b0 || level !== LW'(1) || cmd !== 4'd0) begin
      errors++;
      $display("FAIL halt_state: halted=%b host_ready=%b level=%0d cmd=%0d, need 1/0/1/0",
               halted, host_ready, level, cmd);
    end
    push_op(4'd5, acc);
    end_push();
    checks++;
    if (acc !== 1'b0 || level !== LW'(1)) begin
      errors++;
      $display("FAIL halt_push: accepted=%b level=%0d, need 0/1", acc, level);
    end
  endtask

  task automatic test_reset_mid();
    logic acc;
    bit ok;
    do_reset();
    ctl_lat = 2; ctl_len = 20;
    for (int i = 1; i <= 5; i++) push_op(4'(i), acc);
    end_push();
    wait_strobes(1, 50, ok);
    repeat (5) @(negedge clk);
    #2;
    checks++;
    if (!ok || busy !== 1'b1 || level !== LW'(4)) begin
      errors++;
      $display("FAIL mid_setup: strobe=%0d busy=%b level=%0d, need 1/1/4", ok, busy, level);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (level !== '0 || cmd_valid !== 1'b0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: level=%0d cmd_valid=%b halted=%b, need 0/0/0",
               level, cmd_valid, halted);
    end
    obs_q.delete();
    exp_q.delete();
    @(negedge clk); #1 reset = 1'b1;
    repeat (8) @(negedge clk);
    #2;
    checks++;
    if (obs_q.size() != 0 || level !== '0 || host_ready !== 1'b1 || halted !== 1'b0) begin
      errors++;
      $display("FAIL mid_release: strobes=%0d level=%0d host_ready=%b halted=%b, need 0/0/1/0",
               obs_q.size(), level, host_ready, halted);
    end
  endtask

  task automatic test_filter();
    logic acc;
    bit ok;
    int n_exp;
    do_reset();
    force_busy = 1'b1;
    push_op(4'd13, acc); push_op(4'd2, acc);
    end_push();
    repeat (2) @(negedge clk);
    #2;
    n_exp = exp_q.size();
    checks++;
    if (level !== LW'(n_exp)) begin
      errors++;
      $display("FAIL filter_level: level=%0d, need %0d", level, n_exp);
    end
    ctl_lat = 1; ctl_len = 2;
    force_busy = 1'b0;
    wait_strobes(n_exp, 100, ok);
    repeat (15) @(negedge clk);
    #2;
    checks++;
    if (obs_q.size() != n_exp) begin
      errors++;
      $display("FAIL filter_count: got %0d strobes, need %0d", obs_q.size(), n_exp);
    end
    for (int i = 0; i < obs_q.size() && i < n_exp; i++) begin
      checks++;
      if (obs_q[i].op !== exp_q[i]) begin
        errors++;
        $display("FAIL filter_op%0d: op=%0d, need %0d", i, obs_q[i].op, exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_full();
    test_timeout();
    test_halt();
    test_reset_mid();
    test_filter();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
